// File: rtl/edge_pkg.sv
// Shared types and sizing helpers for the edge event capture block.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Counter must hold 0..DEBOUNCE_CYCLES.
    function automatic int dbc_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/edge_event_capture_if.sv
// Channel inputs and event outputs of edge_event_capture; slave is the block side.
interface edge_event_capture_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   a_i;
    logic [2*CHANNELS-1:0] mode_i;
    logic [CHANNELS-1:0]   clear_i;
    logic [CHANNELS-1:0]   level_o;
    logic [CHANNELS-1:0]   rising_edge_o;
    logic [CHANNELS-1:0]   falling_edge_o;
    logic [CHANNELS-1:0]   pending_o;
    logic                  irq_o;

    modport master (
        output a_i, mode_i, clear_i,
        input  level_o, rising_edge_o, falling_edge_o, pending_o, irq_o
    );

    modport slave (
        input  a_i, mode_i, clear_i,
        output level_o, rising_edge_o, falling_edge_o, pending_o, irq_o
    );
endinterface

// File: rtl/edge_debounce_ch.sv
// One channel: synchroniser chain, debounce counter, filtered level and registered edge pulses.
// Filtered level and pulses update SYNC_STAGES+DEBOUNCE_CYCLES edges after the input change.
module edge_debounce_ch
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic a_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int               CNT_W    = dbc_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flt_q, flt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], a_i};
        cnt_d  = cnt_q;
        flt_d  = flt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync == flt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // New level has persisted long enough: accept it and pulse once.
            flt_d  = sync;
            cnt_d  = '0;
            rise_d = sync;
            fall_d = ~sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            flt_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            flt_q  <= flt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = flt_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel debounced edge detector with mode-gated sticky pending flags and one irq line.
// Pulses at SYNC_STAGES+DEBOUNCE_CYCLES edges after input change, pending one edge later; no backpressure.
module edge_event_capture
    import edge_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    edge_event_capture_if.slave bus
);
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] ev;
    logic [CHANNELS-1:0] pend_q, pend_d;
    edge_mode_e          mode_c;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        edge_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .a_i     (bus.a_i[c]),
            .level_o (level[c]),
            .rise_o  (rise[c]),
            .fall_o  (fall[c])
        );
    end

    // Mode only gates what reaches pending; the pulses themselves are never masked.
    always_comb begin
        ev     = '0;
        mode_c = EDGE_OFF;
        for (int c = 0; c < CHANNELS; c++) begin
            mode_c = edge_mode_e'(bus.mode_i[2*c +: 2]);
            ev[c]  = (rise[c] & ((mode_c == EDGE_RISE) || (mode_c == EDGE_BOTH))) |
                     (fall[c] & ((mode_c == EDGE_FALL) || (mode_c == EDGE_BOTH)));
        end
        pend_d = (pend_q & ~bus.clear_i) | ev;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign bus.level_o        = level;
    assign bus.rising_edge_o  = rise;
    assign bus.falling_edge_o = fall;
    assign bus.pending_o      = pend_q;
    assign bus.irq_o          = |pend_q;
endmodule

// File: tb/tb_edge_event_capture.sv
// Two configurations (defaults, and 8 ch / 3 sync / 1 debounce) checked every cycle against a window-based model.
module tb_edge_event_capture;
    import edge_pkg::*;

    localparam int NA = 4, SA = 2, DA = 4;
    localparam int NB = 8, SB = 3, DB = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    edge_event_capture_if #(.CHANNELS(NA)) ifa ();
    edge_event_capture_if #(.CHANNELS(NB)) ifb ();

    edge_event_capture #(.CHANNELS(NA), .SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    edge_event_capture #(.CHANNELS(NB), .SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    int n_cmp = 0;
    int n_err = 0;
    int edge_no = 0;
    int rc_a[NA];
    int fc_a[NA];

    // Model: sync is the input delayed SYNC_STAGES edges; the filtered level flips
    // once the last DEBOUNCE_CYCLES synced samples all disagree with it.
    bit aq[2][8][$];
    bit wq[2][8][$];
    bit m_flt[2][8];
    bit m_rise[2][8];
    bit m_fall[2][8];
    bit m_pend[2][8];

    function automatic int n_of(input int ii); return (ii == 0) ? NA : NB; endfunction
    function automatic int s_of(input int ii); return (ii == 0) ? SA : SB; endfunction
    function automatic int d_of(input int ii); return (ii == 0) ? DA : DB; endfunction

    task automatic model_reset();
        for (int ii = 0; ii < 2; ii++) begin
            for (int c = 0; c < 8; c++) begin
                m_flt[ii][c] = 0; m_rise[ii][c] = 0; m_fall[ii][c] = 0; m_pend[ii][c] = 0;
                aq[ii][c] = {};
                wq[ii][c] = {};
                for (int k = 0; k < s_of(ii); k++) aq[ii][c].push_back(1'b0);
                for (int k = 0; k < d_of(ii); k++) wq[ii][c].push_back(1'b0);
            end
        end
    endtask

    task automatic model_edge(input int ii, input logic [7:0] a, input logic [15:0] mode,
                              input logic [7:0] clr);
        bit sb, all, np;
        for (int c = 0; c < n_of(ii); c++) begin
            np = (m_pend[ii][c] & ~clr[c]) | (m_rise[ii][c] & mode[2*c]) |
                 (m_fall[ii][c] & mode[2*c+1]);
            sb = aq[ii][c].pop_front();
            aq[ii][c].push_back(a[c]);
            void'(wq[ii][c].pop_front());
            wq[ii][c].push_back(sb);
            all = 1;
            for (int k = 0; k < wq[ii][c].size(); k++)
                if (wq[ii][c][k] == m_flt[ii][c]) all = 0;
            m_rise[ii][c] = all & ~m_flt[ii][c];
            m_fall[ii][c] = all & m_flt[ii][c];
            if (all) m_flt[ii][c] = ~m_flt[ii][c];
            m_pend[ii][c] = np;
        end
    endtask

    function automatic logic [7:0] mv(input int ii, input int kind);
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < n_of(ii); c++)
            case (kind)
                0:       v[c] = m_flt[ii][c];
                1:       v[c] = m_rise[ii][c];
                2:       v[c] = m_fall[ii][c];
                default: v[c] = m_pend[ii][c];
            endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_no, obs, expv);
        end
    endtask

    task automatic check_inst(input int ii, input logic [7:0] lv, input logic [7:0] rv,
                              input logic [7:0] fv, input logic [7:0] pv, input logic iq);
        string p;
        p = (ii == 0) ? "a" : "b";
        chk({p, ".level"},   32'(lv), 32'(mv(ii, 0)));
        chk({p, ".rise"},    32'(rv), 32'(mv(ii, 1)));
        chk({p, ".fall"},    32'(fv), 32'(mv(ii, 2)));
        chk({p, ".pending"}, 32'(pv), 32'(mv(ii, 3)));
        chk({p, ".irq"},     32'(iq), 32'(|mv(ii, 3)));
    endtask

    task automatic step();
        logic [7:0]  a0, c0, a1, c1;
        logic [15:0] m0, m1;
        a0 = 8'(ifa.a_i);  c0 = 8'(ifa.clear_i); m0 = 16'(ifa.mode_i);
        a1 = ifb.a_i;      c1 = ifb.clear_i;     m1 = ifb.mode_i;
        @(posedge clk);
        model_edge(0, a0, m0, c0);
        model_edge(1, a1, m1, c1);
        #1;
        edge_no++;
        for (int c = 0; c < NA; c++) begin
            rc_a[c] += int'(ifa.rising_edge_o[c]);
            fc_a[c] += int'(ifa.falling_edge_o[c]);
        end
        check_inst(0, 8'(ifa.level_o), 8'(ifa.rising_edge_o), 8'(ifa.falling_edge_o),
                   8'(ifa.pending_o), ifa.irq_o);
        check_inst(1, ifb.level_o, ifb.rising_edge_o, ifb.falling_edge_o, ifb.pending_o, ifb.irq_o);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst.a_outs", {ifa.level_o, ifa.rising_edge_o, ifa.falling_edge_o, ifa.pending_o}, 32'h0);
        chk("rst.a_irq", 32'(ifa.irq_o), 32'h0);
        chk("rst.b_outs", {ifb.level_o, ifb.rising_edge_o, ifb.falling_edge_o, ifb.pending_o}, 32'h0);
        chk("rst.b_irq", 32'(ifb.irq_o), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        edge_no = 0;
    endtask

    task automatic clr_counts();
        for (int c = 0; c < NA; c++) begin rc_a[c] = 0; fc_a[c] = 0; end
    endtask

    int lat_a, lat_b, lat_r;
    logic [7:0] rv_a, rv_b;
    logic found;
    logic [7:0] nv;

    initial begin
        ifa.a_i = '0; ifa.mode_i = '0; ifa.clear_i = '0;
        ifb.a_i = '0; ifb.mode_i = '0; ifb.clear_i = '0;
        clr_counts();
        #2;
        do_reset();

        // Latency: ch0 rise mode on A, all channels at once on B.
        ifa.mode_i[1:0] = EDGE_RISE;
        ifa.a_i[0] = 1'b1;
        ifb.mode_i = '1;
        ifb.a_i = 8'hFF;
        lat_a = -1; lat_b = -1; rv_a = '0; rv_b = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (lat_a < 0 && ifa.rising_edge_o[0]) begin lat_a = edge_no; rv_a = 8'(ifa.rising_edge_o); end
            if (lat_b < 0 && ifb.rising_edge_o[0]) begin lat_b = edge_no; rv_b = ifb.rising_edge_o; end
            if (edge_no == 6) chk("a.pend_before", 32'(ifa.pending_o[0]), 32'h0);
            if (edge_no == 7) begin
                chk("a.pend_lat", 32'(ifa.pending_o[0]), 32'h1);
                chk("a.irq_lat", 32'(ifa.irq_o), 32'h1);
            end
        end
        chk("a.latency", 32'(lat_a), 32'd6);
        chk("a.rise_only_ch0", 32'(rv_a), 32'h1);
        chk("b.latency", 32'(lat_b), 32'(SB + DB));
        chk("b.rise_all", 32'(rv_b), 32'hFF);

        // Glitch of 3 cycles on ch1, then a 4-cycle pulse.
        clr_counts();
        ifa.a_i[1] = 1'b1; repeat (3) step();
        ifa.a_i[1] = 1'b0; repeat (10) step();
        chk("glitch.rise", 32'(rc_a[1]), 32'd0);
        chk("glitch.level", 32'(ifa.level_o[1]), 32'h0);
        ifa.a_i[1] = 1'b1; repeat (4) step();
        ifa.a_i[1] = 1'b0; repeat (12) step();
        chk("pulse4.rise", 32'(rc_a[1]), 32'd1);
        chk("pulse4.fall", 32'(fc_a[1]), 32'd1);

        // Modes on ch2.
        clr_counts();
        ifa.mode_i[5:4] = EDGE_OFF;
        ifa.a_i[2] = 1'b1; repeat (8) step();
        ifa.a_i[2] = 1'b0; repeat (8) step();
        chk("off.pulses", 32'(rc_a[2] + fc_a[2]), 32'd2);
        chk("off.pend", 32'(ifa.pending_o[2]), 32'h0);
        ifa.mode_i[5:4] = EDGE_FALL;
        ifa.a_i[2] = 1'b1; repeat (8) step();
        chk("fall.no_rise_pend", 32'(ifa.pending_o[2]), 32'h0);
        ifa.a_i[2] = 1'b0; repeat (8) step();
        chk("fall.pend", 32'(ifa.pending_o[2]), 32'h1);
        ifa.mode_i[5:4] = EDGE_BOTH;
        ifa.clear_i[2] = 1'b1; step(); ifa.clear_i[2] = 1'b0;
        chk("both.cleared", 32'(ifa.pending_o[2]), 32'h0);
        ifa.a_i[2] = 1'b1; repeat (8) step();
        chk("both.rise_pend", 32'(ifa.pending_o[2]), 32'h1);
        ifa.clear_i[2] = 1'b1; step(); ifa.clear_i[2] = 1'b0;
        ifa.a_i[2] = 1'b0; repeat (8) step();
        chk("both.fall_pend", 32'(ifa.pending_o[2]), 32'h1);

        // Clear colliding with a new event on ch3, then plain clears.
        ifa.mode_i[7:6] = EDGE_BOTH;
        ifa.a_i[3] = 1'b1; repeat (8) step();
        ifa.a_i[3] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            found = ifa.falling_edge_o[3];
        end
        chk("collide.fall_seen", 32'(found), 32'h1);
        ifa.clear_i[3] = 1'b1; step(); ifa.clear_i[3] = 1'b0;
        chk("collide.pend", 32'(ifa.pending_o[3]), 32'h1);
        ifa.clear_i[3] = 1'b1; step(); ifa.clear_i[3] = 1'b0;
        chk("clear.pend", 32'(ifa.pending_o[3]), 32'h0);
        chk("clear.irq_held", 32'(ifa.irq_o), 32'h1);
        ifa.clear_i = '1; step(); ifa.clear_i = '0;
        chk("clear.irq_drop", 32'(ifa.irq_o), 32'h0);

        // Reset in the middle of a debounce, input held through release.
        ifa.a_i[1] = 1'b1; repeat (3) step();
        do_reset();
        lat_r = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (lat_r < 0 && ifa.rising_edge_o[1]) lat_r = edge_no;
        end
        chk("rst.relatency", 32'(lat_r), 32'd6);

        // Random traffic on both configurations.
        for (int k = 0; k < 400; k++) begin
            nv = 8'(ifa.a_i);
            for (int c = 0; c < NA; c++) if ($urandom_range(7) == 0) nv[c] = ~nv[c];
            ifa.a_i = nv[NA-1:0];
            nv = ifb.a_i;
            for (int c = 0; c < NB; c++) if ($urandom_range(5) == 0) nv[c] = ~nv[c];
            ifb.a_i = nv;
            if (k % 32 == 0) begin
                ifa.mode_i = 8'($urandom);
                ifb.mode_i = 16'($urandom);
            end
            ifa.clear_i = 4'($urandom & $urandom & $urandom);
            ifb.clear_i = 8'($urandom & $urandom & $urandom);
            step();
        end
        ifa.clear_i = '0; ifb.clear_i = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/edge_event_capture.md
# edge_event_capture

Multi-channel, parametrised edge detector for asynchronous or bouncy inputs such as buttons, external strobes and status lines. Each channel is synchronised, debounced and edge-detected, producing registered single-cycle rise and fall pulses. A per-channel mode selects which edges raise a sticky pending flag. Pending flags are cleared by software-style pulses and are ORed into one interrupt line for the surrounding control logic.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 4: consecutive cycles a new synchronised level must persist before acceptance (≥1).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- a_i  input  CHANNELS  raw channel inputs; may be asynchronous to clk.
- mode_i  input  2*CHANNELS  per-channel event mode, bits [2c+1:2c]:
  - 00: off.
  - 01: rising edges.
  - 10: falling edges.
  - 11: both edges.
- clear_i  input  CHANNELS  single-cycle pulse clears the corresponding pending bit.
- level_o  output  CHANNELS  debounced (filtered) level per channel.
- rising_edge_o  output  CHANNELS  one-cycle pulse when the filtered level goes 0→1.
- falling_edge_o  output  CHANNELS  one-cycle pulse when the filtered level goes 1→0.
- pending_o  output  CHANNELS  sticky event flags.
- irq_o  output  1  OR of all pending_o bits.

## Operation
- Synchroniser, per channel: a shift chain of SYNC_STAGES flops; sync = last stage.
- Debounce, per channel:
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1), plus filtered register flt.
  - sync == flt: cnt ← 0.
  - sync != flt and cnt == DEBOUNCE_CYCLES-1: flt ← sync, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync resets the count and never changes flt.
- Edge pulses are registered and written on the same clock edge as flt:
  - rising_edge_o[c] is 1 exactly in the cycle flt first reads 1.
  - falling_edge_o[c] is 1 exactly in the cycle flt first reads 0.
  - Pulses never overlap on one channel.
- level_o = flt.
- Event, per channel: ev = (rise & mode[0]) | (fall & mode[1]). mode_i gates pending only, never the edge pulses.
- Pending, per channel:
  - ev sets the bit; clear_i clears it.
  - ev and clear_i in the same cycle: set wins, pending stays 1.
  - Clear of an already-clear bit: no effect.
- irq_o = |pending_o, combinational from the pending register.
- mode_i is sampled every cycle. A mode change does not alter existing pending bits.

## Timing
- Reset (async assert, sync release): all sync flops, flt, cnt, edge pulses and pending are 0. All outputs are 0.
- An input held high through reset release produces a rising edge after the normal latency.
- Latency: input change first sampled at clock edge 1 → flt, level_o and edge pulse update at edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: edge 6.
- pending_o updates at the edge after the pulse (latency +1). irq_o follows in the same cycle as pending_o.
- clear_i asserted in cycle n → pending bit 0 from edge n+1, unless a new event coincides.
- Reset mid-debounce: count discarded, no pulse emitted.

## Structure
- Shared package edge_pkg:
  - edge_mode_e enum: EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - Width helper constant for the debounce counter.
- Sub-module edge_debounce_ch: one channel's synchroniser, debounce counter, flt and edge pulses, with parameters SYNC_STAGES and DEBOUNCE_CYCLES.
- The top level instantiates edge_debounce_ch CHANNELS times in a generate loop. Mode gating, pending registers and irq_o live in the top level.

## Test plan
- Defaults, ch0 mode 01: a_i[0] 0→1 held → rising_edge_o[0] one-cycle pulse at edge 6, level_o[0]=1, pending_o[0]=1 and irq_o=1 at edge 7. No pulse on other channels.
- Glitch, DEBOUNCE_CYCLES=4: a_i[1] high for 3 cycles then low → no pulse, level_o[1] stays 0. Held for 4 cycles at sync output → exactly one rise, then one fall on return to 0.
- Modes on ch2:
  - 00: toggle → edge pulses occur, pending stays 0.
  - 10: only the falls set pending.
  - 11: both edges set pending.
- Clear collision: pending_o[3]=1, then clear_i[3] in the same cycle as a new event → pending_o[3] stays 1. Clear alone → 0 next edge. irq_o drops only when all pending bits are 0.
- Reset: assert reset mid-debounce with a_i high → all outputs 0 immediately. Hold a_i high through release → rising pulse at edge 6 after release.
- Parameter sweep CHANNELS=1/8, SYNC_STAGES=3, DEBOUNCE_CYCLES=1 → latency = SYNC_STAGES+DEBOUNCE_CYCLES edges. Simultaneous edges on all channels are each reported once.
